// File: rtl/vx_tex_mem_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vx_tex_mem_sched: gathers up to 4 texels per lane via round-based dcache  |
// | reads (one texel index per round) and hands the set to the sampler.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vx_tex_mem_sched #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int META_W    = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [NUM_LANES-1:0]          req_tmask_i,
  input  logic [NUM_LANES*4*ADDR_W-1:0] req_addr_i,
  input  logic [META_W-1:0]             req_meta_i,
  output logic [NUM_LANES-1:0]          dcache_req_valid_o,
  input  logic [NUM_LANES-1:0]          dcache_req_ready_i,
  output logic                          dcache_req_rw_o,
  output logic [NUM_LANES*ADDR_W-1:0]   dcache_req_addr_o,
  output logic [1:0]                    dcache_req_tag_o,
  input  logic                          dcache_rsp_valid_i,
  input  logic [NUM_LANES-1:0]          dcache_rsp_tmask_i,
  input  logic [NUM_LANES*DATA_W-1:0]   dcache_rsp_data_i,
  input  logic [1:0]                    dcache_rsp_tag_i,
  output logic                          dcache_rsp_ready_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [NUM_LANES-1:0]          rsp_tmask_o,
  output logic [NUM_LANES*4*DATA_W-1:0] rsp_texels_o,
  output logic [META_W-1:0]             rsp_meta_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  function automatic logic [2:0] popcnt(input logic [NUM_LANES-1:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) c = c + {2'b00, m[i]};
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] tmask_q, tmask_d;
  logic [NUM_LANES-1:0] sent_q, sent_d;
  logic [1:0]           tidx_q, tidx_d;
  logic [4:0]           expected_q, expected_d;
  logic [4:0]           received_q, received_d;
  logic [ADDR_W-1:0]    addr_q  [NUM_LANES][4];
  logic [DATA_W-1:0]    texel_q [NUM_LANES][4];
  logic [META_W-1:0]    meta_q;

  logic                 req_fire;
  logic                 issuing;
  logic                 done;
  logic [NUM_LANES-1:0] req_acc;
  logic                 round_done;
  logic                 rsp_fire;
  logic [NUM_LANES-1:0] rsp_mask;
  logic [4:0]           rsp_cnt;
  logic                 rsp_over;
  logic                 rsp_take;

  assign issuing            = (state_q == ISSUE);
  assign done               = (state_q == DONE);
  assign req_ready_o        = (state_q == IDLE);
  assign req_fire           = req_valid_i & req_ready_o;
  assign dcache_req_valid_o = issuing ? (tmask_q & ~sent_q) : '0;
  assign dcache_req_rw_o    = 1'b0;
  assign dcache_req_tag_o   = tidx_q;
  assign req_acc            = dcache_req_valid_o & dcache_req_ready_i;
  assign round_done         = issuing && ((sent_q | req_acc) == tmask_q);

  // Responses are accepted in ISSUE as well, so early rounds can land while later ones issue.
  assign dcache_rsp_ready_o = issuing || (state_q == WAIT);
  assign rsp_fire           = dcache_rsp_valid_i & dcache_rsp_ready_o;
  assign rsp_mask           = dcache_rsp_tmask_i & tmask_q;
  assign rsp_cnt            = {2'b00, popcnt(rsp_mask)};
  assign rsp_over           = (received_q + rsp_cnt) > expected_q;
  assign rsp_take           = rsp_fire & ~rsp_over;

  assign rsp_valid_o = done;
  assign rsp_tmask_o = done ? tmask_q : '0;
  assign rsp_meta_o  = done ? meta_q : '0;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign dcache_req_addr_o[l*ADDR_W +: ADDR_W] = addr_q[l][tidx_q];
    for (genvar t = 0; t < 4; t++) begin : g_tex
      assign rsp_texels_o[(l*4+t)*DATA_W +: DATA_W] = done ? texel_q[l][t] : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmask_d    = tmask_q;
    sent_d     = sent_q;
    tidx_d     = tidx_q;
    expected_d = expected_q;
    received_d = received_q;
    if (rsp_take) received_d = received_q + rsp_cnt;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          tmask_d    = req_tmask_i;
          expected_d = {popcnt(req_tmask_i), 2'b00};
          received_d = 5'd0;
          tidx_d     = 2'd0;
          sent_d     = '0;
          state_d    = (req_tmask_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        sent_d = sent_q | req_acc;
        if (round_done) begin
          sent_d = '0;
          tidx_d = tidx_q + 2'd1;
          if (tidx_q == 2'd3) state_d = (received_d == expected_q) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (received_d == expected_q) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tmask_q    <= '0;
      sent_q     <= '0;
      tidx_q     <= 2'd0;
      expected_q <= 5'd0;
      received_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      tmask_q    <= tmask_d;
      sent_q     <= sent_d;
      tidx_q     <= tidx_d;
      expected_q <= expected_d;
      received_q <= received_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int t = 0; t < 4; t++) begin
          addr_q[l][t]  <= '0;
          texel_q[l][t] <= '0;
        end
      end
    end else if (req_fire) begin
      meta_q <= req_meta_i;
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int t = 0; t < 4; t++) begin
          addr_q[l][t]  <= req_addr_i[(l*4+t)*ADDR_W +: ADDR_W];
          texel_q[l][t] <= '0;
        end
      end
    end else if (rsp_take) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (rsp_mask[l]) texel_q[l][dcache_rsp_tag_i] <= dcache_rsp_data_i[l*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && rsp_fire) begin
      assert ((dcache_rsp_tmask_i & ~tmask_q) == '0);
      assert (!rsp_over);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_tex_mem_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vx_tex_mem_sched: self-checking bench with a dcache responder model.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vx_tex_mem_sched;
  localparam int NL = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [NL-1:0]     req_tmask = '0;
  logic [NL*4*AW-1:0] req_addr = '0;
  logic [MW-1:0]     req_meta = '0;
  logic [NL-1:0]     dc_req_valid;
  logic [NL-1:0]     dc_req_ready;
  logic              dc_req_rw;
  logic [NL*AW-1:0]  dc_req_addr;
  logic [1:0]        dc_req_tag;
  logic              dc_rsp_valid;
  logic [NL-1:0]     dc_rsp_tmask;
  logic [NL*DW-1:0]  dc_rsp_data;
  logic [1:0]        dc_rsp_tag;
  logic              dc_rsp_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [NL-1:0]     rsp_tmask;
  logic [NL*4*DW-1:0] rsp_texels;
  logic [MW-1:0]     rsp_meta;

  always #5 clk = ~clk;

  vx_tex_mem_sched #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .META_W(MW)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_tmask_i(req_tmask),
    .req_addr_i(req_addr), .req_meta_i(req_meta),
    .dcache_req_valid_o(dc_req_valid), .dcache_req_ready_i(dc_req_ready),
    .dcache_req_rw_o(dc_req_rw), .dcache_req_addr_o(dc_req_addr), .dcache_req_tag_o(dc_req_tag),
    .dcache_rsp_valid_i(dc_rsp_valid), .dcache_rsp_tmask_i(dc_rsp_tmask),
    .dcache_rsp_data_i(dc_rsp_data), .dcache_rsp_tag_i(dc_rsp_tag), .dcache_rsp_ready_o(dc_rsp_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tmask_o(rsp_tmask),
    .rsp_texels_o(rsp_texels), .rsp_meta_o(rsp_meta)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int popc(input logic [3:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
  endfunction

  // Current transaction as seen by the reference model
  logic [3:0]  cur_tmask = '0;
  logic [31:0] cur_addr [4][4];
  logic [63:0] cur_meta = '0;
  logic [15:0] fired = '0;   // bit l*4+t: lane l issued texel t
  logic [15:0] pend = '0;    // issued but not yet answered
  int          fire_cnt = 0;
  int          acc_cnt = 0;
  int          rdy_mode = 0; // 0 always ready, 1 random
  int          rsp_mode = 0; // 0 in order, 1 random split/reorder, 2 fixed split/reorder
  int          stall_l1 = 0;
  int          seq_step = 0;
  bit          stale_on = 1'b0;
  int          seq_tag [8] = '{3, 3, 0, 0, 2, 2, 1, 1};

  function automatic logic [511:0] exp_texels();
    logic [511:0] e;
    e = '0;
    for (int l = 0; l < 4; l++)
      for (int t = 0; t < 4; t++)
        if (cur_tmask[l]) e[(l*4+t)*32 +: 32] = cur_addr[l][t];
    return e;
  endfunction

  // dcache model: monitors issued reads and answers them
  initial begin : dc_model
    logic       acc;
    logic       real_drv;
    logic [3:0] prev_stall;
    logic [31:0] prev_addr [4];
    logic [3:0] m;
    logic [3:0] prevdone;
    int         t;
    int         tsel;
    dc_req_ready = '1;
    dc_rsp_valid = 1'b0;
    dc_rsp_tmask = '0;
    dc_rsp_data  = '0;
    dc_rsp_tag   = '0;
    real_drv     = 1'b0;
    prev_stall   = '0;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      if (reset) begin
        pend = '0;
        prev_stall = '0;
      end else begin
        acc = dc_rsp_valid && dc_rsp_ready;
        if (acc && real_drv) begin
          acc_cnt += popc(dc_rsp_tmask);
          for (int l = 0; l < 4; l++) if (dc_rsp_tmask[l]) pend[l*4+int'(dc_rsp_tag)] = 1'b0;
        end
        if (|dc_req_valid) chk("req_rw", {511'd0, dc_req_rw}, 512'd0);
        if (dc_req_valid[1] && stall_l1 > 0) stall_l1--;
        for (int l = 0; l < 4; l++) begin
          if (prev_stall[l]) begin
            chk("hold_valid", {511'd0, dc_req_valid[l]}, 512'd1);
            chk("hold_addr", {480'd0, dc_req_addr[l*32 +: 32]}, {480'd0, prev_addr[l]});
          end
          if (dc_req_valid[l] && dc_req_ready[l]) begin
            t = int'(dc_req_tag);
            chk("fire_lane_active", {511'd0, cur_tmask[l]}, 512'd1);
            chk("fire_addr", {480'd0, dc_req_addr[l*32 +: 32]}, {480'd0, cur_addr[l][t]});
            chk("fire_dup", {511'd0, fired[l*4+t]}, 512'd0);
            if (t > 0) begin
              for (int k = 0; k < 4; k++) prevdone[k] = fired[k*4+t-1];
              chk("fire_order", {508'd0, prevdone & cur_tmask}, {508'd0, cur_tmask});
            end
            fired[l*4+t] = 1'b1;
            pend[l*4+t]  = 1'b1;
            fire_cnt++;
          end
          prev_stall[l] = dc_req_valid[l] & ~dc_req_ready[l];
          prev_addr[l]  = dc_req_addr[l*32 +: 32];
        end
      end
      @(posedge clk);
      #1;
      for (int l = 0; l < 4; l++) dc_req_ready[l] = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (stall_l1 > 0) dc_req_ready[1] = 1'b0;
      if (stale_on) begin
        dc_rsp_valid = 1'b1;
        dc_rsp_tag   = 2'd1;
        dc_rsp_tmask = 4'hF;
        dc_rsp_data  = {4{32'hDEAD_BEEF}};
        real_drv     = 1'b0;
      end else if (reset) begin
        dc_rsp_valid = 1'b0;
        real_drv     = 1'b0;
      end else if (!(dc_rsp_valid && real_drv && !acc)) begin
        dc_rsp_valid = 1'b0;
        real_drv     = 1'b0;
        tsel = -1;
        if (rsp_mode == 0) begin
          for (int k = 3; k >= 0; k--) if ({pend[12+k], pend[8+k], pend[4+k], pend[k]} != 4'h0) tsel = k;
        end else if (rsp_mode == 1) begin
          if (pend != '0 && $urandom_range(0, 1) == 1) begin
            do tsel = int'($urandom_range(0, 3));
            while ({pend[12+tsel], pend[8+tsel], pend[4+tsel], pend[tsel]} == 4'h0);
          end
        end else if (fired == 16'hFFFF && seq_step < 8) begin
          tsel = seq_tag[seq_step];
        end
        if (tsel >= 0) begin
          m = {pend[12+tsel], pend[8+tsel], pend[4+tsel], pend[tsel]};
          if (rsp_mode == 1 && (m & 4'($urandom())) != 4'h0) m = m & 4'($urandom());
          if (rsp_mode == 2) begin
            m = m & (seq_step[0] ? 4'b1100 : 4'b0011);
            seq_step++;
          end
          if (m != 4'h0) begin
            dc_rsp_valid = 1'b1;
            real_drv     = 1'b1;
            dc_rsp_tag   = 2'(tsel);
            dc_rsp_tmask = m;
            for (int l = 0; l < 4; l++)
              dc_rsp_data[l*32 +: 32] = m[l] ? cur_addr[l][tsel] : $urandom();
          end
        end
      end
    end
  end

  task automatic load_req(input logic [3:0] tm, input logic [31:0] base, input logic rnd);
    cur_tmask = tm;
    cur_meta  = {$urandom(), $urandom()};
    for (int l = 0; l < 4; l++)
      for (int t = 0; t < 4; t++)
        cur_addr[l][t] = rnd ? $urandom() : base + 32'(16*l + 4*t);
  endtask

  task automatic drive_req();
    fired = '0; pend = '0; fire_cnt = 0; acc_cnt = 0; seq_step = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_tmask = cur_tmask;
    req_meta  = cur_meta;
    for (int l = 0; l < 4; l++)
      for (int t = 0; t < 4; t++) req_addr[(l*4+t)*32 +: 32] = cur_addr[l][t];
    @(negedge clk);
    chk("req_ready", {511'd0, req_ready}, 512'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input string nm, input int exp_lat, input int exp_fires, input int stall);
    int lat;
    bit got;
    drive_req();
    lat = 0;
    got = 1'b0;
    while (lat < 300 && !got) begin
      @(negedge clk);
      lat++;
      got = rsp_valid;
    end
    chk({nm, "_timeout"}, {511'd0, got}, 512'd1);
    if (got) begin
      if (exp_lat >= 0) chk({nm, "_latency"}, 512'(lat), 512'(exp_lat));
      chk({nm, "_tmask"}, {508'd0, rsp_tmask}, {508'd0, cur_tmask});
      chk({nm, "_meta"}, {448'd0, rsp_meta}, {448'd0, cur_meta});
      chk({nm, "_texels"}, rsp_texels, exp_texels());
      chk({nm, "_words_rcvd"}, 512'(acc_cnt), 512'(4*popc(cur_tmask)));
      chk({nm, "_fires"}, 512'(fire_cnt), 512'(exp_fires));
      chk({nm, "_req_ready_busy"}, {511'd0, req_ready}, 512'd0);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, "_stall_valid"}, {511'd0, rsp_valid}, 512'd1);
      chk({nm, "_stall_meta"}, {448'd0, rsp_meta}, {448'd0, cur_meta});
      chk({nm, "_stall_texels"}, rsp_texels, exp_texels());
      chk({nm, "_stall_req_ready"}, {511'd0, req_ready}, 512'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_post_valid"}, {511'd0, rsp_valid}, 512'd0);
    chk({nm, "_post_req_ready"}, {511'd0, req_ready}, 512'd1);
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  tmask;
    int          rdy;
    int          rsp;
    int          stall_l1;
    int          rsp_stall;
    int          exp_lat;
    int          exp_fires;
    logic [31:0] base;
  } vec_t;

  vec_t vt [5];

  initial begin : main
    vt[0] = '{"bilinear",  4'b1111, 0, 0, 0, 0, 6,  16, 32'h1000};
    vt[1] = '{"partial",   4'b0101, 0, 0, 0, 0, 6,  8,  32'h2000};
    vt[2] = '{"backpress", 4'b1111, 0, 0, 3, 0, 9,  16, 32'h3000};
    vt[3] = '{"split_ooo", 4'b1111, 0, 2, 0, 0, 13, 16, 32'h4000};
    vt[4] = '{"empty",     4'b0000, 0, 0, 0, 5, 1,  0,  32'h5000};

    #12;
    chk("rst_dc_valid", {508'd0, dc_req_valid}, 512'd0);
    chk("rst_dc_rsp_ready", {511'd0, dc_rsp_ready}, 512'd0);
    chk("rst_rsp_valid", {511'd0, rsp_valid}, 512'd0);
    chk("rst_rsp_tmask", {508'd0, rsp_tmask}, 512'd0);
    chk("rst_rsp_texels", rsp_texels, 512'd0);
    chk("rst_rsp_meta", {448'd0, rsp_meta}, 512'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {511'd0, req_ready}, 512'd1);

    for (int i = 0; i < 5; i++) begin
      rdy_mode = vt[i].rdy;
      rsp_mode = vt[i].rsp;
      stall_l1 = vt[i].stall_l1;
      load_req(vt[i].tmask, vt[i].base, 1'b0);
      run_txn(vt[i].nm, vt[i].exp_lat, vt[i].exp_fires, vt[i].rsp_stall);
    end

    // Reset in the middle of round 2, then stale responses, then a fresh request
    rdy_mode = 0;
    rsp_mode = 0;
    load_req(4'hF, 32'h6000, 1'b0);
    drive_req();
    repeat (3) @(negedge clk);
    chk("midrst_tag", {510'd0, dc_req_tag}, 512'd2);
    #2 reset = 1'b1;
    #1;
    chk("midrst_dc_valid", {508'd0, dc_req_valid}, 512'd0);
    chk("midrst_rsp_ready", {511'd0, dc_rsp_ready}, 512'd0);
    chk("midrst_rsp_valid", {511'd0, rsp_valid}, 512'd0);
    chk("midrst_texels", rsp_texels, 512'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {511'd0, req_ready}, 512'd1);
    stale_on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stale_rsp_ready", {511'd0, dc_rsp_ready}, 512'd0);
    end
    stale_on = 1'b0;
    load_req(4'hF, 32'h7000, 1'b0);
    run_txn("after_rst", 6, 16, 0);

    for (int i = 0; i < 40; i++) begin
      rdy_mode = int'($urandom_range(0, 1));
      rsp_mode = int'($urandom_range(0, 1));
      stall_l1 = 0;
      load_req(4'($urandom()), 32'h0, 1'b1);
      run_txn("rand", -1, 4*popc(cur_tmask), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_tex_mem_sched.md
Name: vx_tex_mem_sched

Overview:
- Memory scheduler inside the texture pipeline; sits directly downstream of the texture address stage and upstream of the sampler/filter stage.
- Accepts one warp-wide texel-fetch request: up to 4 texel addresses per active lane, covering point and bilinear sampling.
- Issues the reads to the dcache port, one texel index per round, and gathers the returned words.
- Presents the completed texel set plus passthrough metadata to the sampler. Only one warp request is in flight at a time.

Parameters:
NUM_LANES, 4, threads per warp / dcache request ports
ADDR_W, 32, byte address width
DATA_W, 32, texel word width
META_W, 64, opaque passthrough metadata (uuid, wid, PC, rd, wb)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  scheduler can accept a request
req_tmask  in  NUM_LANES  active lanes
req_addr  in  NUM_LANES*4*ADDR_W  texel addresses; lane l, texel t at index (l*4+t)
req_meta  in  META_W  passthrough metadata
dcache_req_valid  out  NUM_LANES  per-lane read request
dcache_req_ready  in  NUM_LANES  per-lane accept
dcache_req_rw  out  1  constant 0 (read)
dcache_req_addr  out  NUM_LANES*ADDR_W  per-lane address
dcache_req_tag  out  2  texel index t of the current round
dcache_rsp_valid  in  1  response valid
dcache_rsp_tmask  in  NUM_LANES  lanes carried by this response
dcache_rsp_data  in  NUM_LANES*DATA_W  per-lane data
dcache_rsp_tag  in  2  texel index t
dcache_rsp_ready  out  1  response accept
rsp_valid  out  1  gathered texels valid
rsp_ready  in  1  sampler accept
rsp_tmask  out  NUM_LANES  copy of req_tmask
rsp_texels  out  NUM_LANES*4*DATA_W  gathered data, same indexing as req_addr
rsp_meta  out  META_W  copy of req_meta

Behaviour:
- Reset (asynchronous): state IDLE; all counters, sent masks and texel storage cleared to 0.
  - During and after reset: dcache_req_valid=0, dcache_rsp_ready=0, rsp_valid=0, rsp_tmask=0, rsp_texels=0, rsp_meta=0.
  - req_ready=1 once in IDLE.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch tmask, addr and meta; clear texel storage;
  - set expected=popcount(tmask)*4 (3-bit popcount, 5-bit counters); set received=0, tidx=0, sent mask=0;
  - go to ISSUE, or go to DONE if tmask==0.
- ISSUE:
  - dcache_req_valid[l] = tmask[l] & ~sent[l]; dcache_req_addr lane l = addr[l][tidx]; dcache_req_tag=tidx.
  - Each cycle, OR (valid & ready) into sent.
  - When sent|accepted == tmask: clear sent and increment tidx. After tidx 3 completes, go to WAIT.
  - The first dcache request is visible the cycle after the request handshake.
  - Lanes stalled by ready=0 hold their address and valid stable (no retraction).
- ISSUE and WAIT: dcache_rsp_ready=1. On dcache_rsp_valid:
  - for each lane l with rsp_tmask[l]&tmask[l], write texel[l][rsp_tag];
  - add popcount(rsp_tmask&tmask) to received. Lanes not in tmask are ignored (simulation assertion fires).
- Responses may arrive in any order, including during ISSUE and in the same cycle as a request handshake. Both counters update the same cycle.
- Transition to DONE when all rounds are issued and the next value of received == expected. This can happen directly from ISSUE on the last round's cycle, if all responses are already in.
- DONE: rsp_valid=1, with outputs stable until rsp_ready. On handshake go to IDLE; req_ready rises the following cycle.
  - Minimum latency from request accept to rsp_valid is 6 cycles (4 issue rounds + 1 response cycle + DONE register), given always-ready dcache and zero-latency responses.
- No overflow: received never exceeds expected. An excess response asserts and is dropped.
- Reset mid-operation aborts immediately. Late dcache responses arriving after reset are dropped because dcache_rsp_ready=0 until a new request enters ISSUE.

Test Plan:
- Single bilinear fetch with tmask=4'b1111, addr(l,t)=0x1000+16*l+4*t, always-ready dcache, 1-cycle response data=addr -> 4 rounds of 4-lane requests with tags 0..3; rsp_texels[l][t]=0x1000+16*l+4*t; rsp_valid asserted 6 cycles after accept.
- Partial mask tmask=4'b0101 -> only lanes 0 and 2 are ever valid; expected=8; rsp_texels for lanes 1 and 3 = 0; rsp_tmask=4'b0101.
- Backpressure with dcache_req_ready[1]=0 for 3 cycles in round 0 -> lane 1 address held stable; lanes 0, 2 and 3 not reissued; tidx advances only after lane 1 is accepted.
- Out-of-order and split responses: tag 3 returned before tag 0, and each tag split into two responses with rsp_tmask 0011 then 1100 -> correct placement; rsp_valid only after all 16 words are received.
- Empty mask plus sampler stall: tmask=0 -> no dcache traffic and DONE the next cycle. Then hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_meta stable, and req_ready=0 throughout.
- Reset asserted in ISSUE round 2 -> outputs clear asynchronously and req_ready=1 after release. Responses with stale tag 1 arriving afterward are not accepted; a fresh request completes correctly.
